// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_pkg
//  Purpose  : Shared constants and helpers for the scoreboarded register file
//  Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  // Default geometry: 32 x 32-bit registers, two read ports
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NRD    = 2;

  // Hard-wired zero register
  localparam int ZERO_REG   = 0;

  // Upper bounds used to size the generic address-extraction helper
  localparam int MAX_ADDR_W = 16;
  localparam int MAX_NRD    = 4;
  localparam int RA_BUS_W   = MAX_ADDR_W * MAX_NRD;

  // Pull port 'port' out of a packed read-address bus with 'addr_w' bits per port
  function automatic logic [MAX_ADDR_W-1:0] port_addr(input logic [RA_BUS_W-1:0] ra_bus,
                                                      input int                  port,
                                                      input int                  addr_w);
    logic [RA_BUS_W-1:0]   shifted;
    logic [MAX_ADDR_W-1:0] mask;
    shifted = ra_bus >> (port * addr_w);
    mask    = {MAX_ADDR_W{1'b1}} >> (MAX_ADDR_W - addr_w);
    return shifted[MAX_ADDR_W-1:0] & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard
//  Purpose  : Per-register pending-write tracking with an incremental
//             count of outstanding producers
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue,
  input  logic [ADDR_W-1:0]      issue_addr,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      wa,
  output logic [2**ADDR_W-1:0]   busy,
  output logic [ADDR_W:0]        pend_cnt
);

  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_next;
  logic [ADDR_W:0]  r_pend;
  logic             w_issue_live;
  logic             w_wb_live;
  logic             w_inc;
  logic             w_dec;

  assign w_issue_live = issue && (issue_addr != ZERO_ADDR);
  assign w_wb_live    = we && (wa != ZERO_ADDR);

  // A new producer beats a concurrent writeback to the same register
  always_comb begin
    w_busy_next = r_busy;
    for (int r = 1; r < DEPTH; r++) begin
      if (issue && (issue_addr == ADDR_W'(r))) begin
        w_busy_next[r] = 1'b1;
      end else if (we && (wa == ADDR_W'(r))) begin
        w_busy_next[r] = 1'b0;
      end
    end
    w_busy_next[0] = 1'b0;
  end

  // Count only real 0->1 and 1->0 transitions so the counter tracks popcount(busy)
  assign w_inc = w_issue_live && !r_busy[issue_addr];
  assign w_dec = w_wb_live && r_busy[wa] && !(w_issue_live && (issue_addr == wa));

  // Busy vector and pending counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      r_pend <= '0;
    end else begin
      r_busy <= w_busy_next;
      r_pend <= r_pend + {{ADDR_W{1'b0}}, w_inc} - {{ADDR_W{1'b0}}, w_dec};
    end
  end

  assign busy     = r_busy;
  assign pend_cnt = r_pend;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : Multi-read-port register file with write-to-read bypass and a
//             pending-write scoreboard for decode-stage stalls
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD-1:0]          ren,
  input  logic [NRD*ADDR_W-1:0]   ra,
  output logic [NRD*WIDTH-1:0]    rd,
  output logic [NRD-1:0]          rbusy,
  output logic                    stall,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       wa,
  input  logic [WIDTH-1:0]        wd,
  input  logic                    issue,
  input  logic [ADDR_W-1:0]       issue_addr,
  output logic [ADDR_W:0]         pend_cnt
);

  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0]    w_busy;
  logic [RA_BUS_W-1:0] w_ra_bus;
  logic [ADDR_W-1:0]   w_addr [NRD];
  logic [NRD-1:0]      w_hit;

  assign w_ra_bus = RA_BUS_W'(ra);

  // Data array: cleared by reset, register 0 never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        r_mem[r] <= '0;
      end
    end else if (we && (wa != ZERO_ADDR)) begin
      r_mem[wa] <= wd;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .issue_addr (issue_addr),
    .we         (we),
    .wa         (wa),
    .busy       (w_busy),
    .pend_cnt   (pend_cnt)
  );

  // Per-port read mux; a same-cycle writeback both forwards data and hides busy
  for (genvar i = 0; i < NRD; i++) begin : g_rdport
    assign w_addr[i] = ADDR_W'(port_addr(w_ra_bus, i, ADDR_W));
    assign w_hit[i]  = we && (wa == w_addr[i]) && (w_addr[i] != ZERO_ADDR);
    assign rd[i*WIDTH +: WIDTH] = (w_addr[i] == ZERO_ADDR) ? '0 :
                                  w_hit[i]                 ? wd : r_mem[w_addr[i]];
    assign rbusy[i] = w_busy[w_addr[i]] & ~w_hit[i];
  end

  assign stall = |(ren & rbusy);

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Purpose  : Self-checking bench for regfile_sb (4 ports, 8 x 32-bit)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 3;
  localparam int NRD    = 4;
  localparam int DEPTH  = 2**ADDR_W;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NRD-1:0]        ren;
  logic [NRD*ADDR_W-1:0] ra;
  logic [NRD*WIDTH-1:0]  rd;
  logic [NRD-1:0]        rbusy;
  logic                  stall;
  logic                  we;
  logic [ADDR_W-1:0]     wa;
  logic [WIDTH-1:0]      wd;
  logic                  issue;
  logic [ADDR_W-1:0]     issue_addr;
  logic [ADDR_W:0]       pend_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state: plain arrays, popcount computed on demand
  logic [WIDTH-1:0] m_mem  [DEPTH];
  bit               m_busy [DEPTH];

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
    .clk        (clk),
    .rst        (rst),
    .ren        (ren),
    .ra         (ra),
    .rd         (rd),
    .rbusy      (rbusy),
    .stall      (stall),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .issue      (issue),
    .issue_addr (issue_addr),
    .pend_cnt   (pend_cnt)
  );

  typedef struct {
    bit               rst;
    bit               we;
    logic [2:0]       wa;
    logic [31:0]      wd;
    bit               issue;
    logic [2:0]       ia;
    logic [3:0]       ren;
    logic [11:0]      ra;
    bit               chk;
    logic [31:0]      e_rd0;
    logic [31:0]      e_rd1;
    logic [3:0]       e_rbusy;
    bit               e_stall;
    logic [3:0]       e_pend;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [11:0] pk(input logic [2:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input bit r, input bit w, input logic [2:0] a, input logic [31:0] d,
                              input bit is, input logic [2:0] ia, input logic [3:0] en,
                              input logic [11:0] rav, input bit c, input logic [31:0] e0,
                              input logic [31:0] e1, input logic [3:0] eb, input bit es,
                              input logic [3:0] ep);
    vec_t v;
    v.rst = r; v.we = w; v.wa = a; v.wd = d; v.issue = is; v.ia = ia; v.ren = en; v.ra = rav;
    v.chk = c; v.e_rd0 = e0; v.e_rd1 = e1; v.e_rbusy = eb; v.e_stall = es; v.e_pend = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst = 0; we = 0; wa = '0; wd = '0; issue = 0; issue_addr = '0; ren = '0; ra = '0;
  endtask

  // Apply the rules of one clock edge to the model
  task automatic model_update();
    bit nb [DEPTH];
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_mem[r]  = '0;
        m_busy[r] = 0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) nb[r] = m_busy[r];
      for (int r = 1; r < DEPTH; r++) begin
        if (issue && issue_addr == r) nb[r] = 1;
        else if (we && wa == r)       nb[r] = 0;
      end
      if (we && wa != 0) m_mem[wa] = wd;
      for (int r = 0; r < DEPTH; r++) m_busy[r] = nb[r];
    end
  endtask

  // Compare all outputs with what the model predicts for the current inputs
  task automatic model_check(input int cyc);
    logic [NRD*WIDTH-1:0] e_rd;
    logic [NRD-1:0]       e_rb;
    logic [ADDR_W:0]      e_pc;
    logic [ADDR_W-1:0]    a;
    e_pc = '0;
    for (int r = 0; r < DEPTH; r++) e_pc = e_pc + (m_busy[r] ? 1 : 0);
    for (int i = 0; i < NRD; i++) begin
      a = ra[i*ADDR_W +: ADDR_W];
      if (a == 0)                e_rd[i*WIDTH +: WIDTH] = '0;
      else if (we && wa == a)    e_rd[i*WIDTH +: WIDTH] = wd;
      else                       e_rd[i*WIDTH +: WIDTH] = m_mem[a];
      e_rb[i] = m_busy[a] && !(we && wa == a);
    end
    chk($sformatf("rnd%0d_rd", cyc), rd, e_rd);
    chk($sformatf("rnd%0d_rbusy", cyc), rbusy, e_rb);
    chk($sformatf("rnd%0d_stall", cyc), stall, |(ren & e_rb));
    chk($sformatf("rnd%0d_pend", cyc), pend_cnt, e_pc);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    idle();
    rst = 1;

    // Directed table: one row per cycle, outputs checked before the edge
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 4'h0, pk(0,0,0,0), 0, 32'h0,        32'h0,        4'h0, 0, 4'd0));
    tbl.push_back(mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 4'h0, pk(5,0,0,0), 1, 32'hDEADBEEF, 32'h0,        4'h0, 0, 4'd0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 4'h0, pk(5,0,0,0), 1, 32'hDEADBEEF, 32'h0,        4'h0, 0, 4'd0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 4'h0, pk(5,0,0,0), 1, 32'h0,        32'h0,        4'h0, 0, 4'd0));
    tbl.push_back(mk(0, 1, 7, 32'h12345678, 0, 0, 4'h0, pk(0,7,0,0), 1, 32'h0,        32'h12345678, 4'h0, 0, 4'd0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 4'h0, pk(0,7,0,0), 1, 32'h0,        32'h12345678, 4'h0, 0, 4'd0));
    tbl.push_back(mk(0, 1, 0, 32'hFFFFFFFF, 1, 0, 4'hF, pk(0,0,0,0), 1, 32'h0,        32'h0,        4'h0, 0, 4'd0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 4'hF, pk(0,0,0,0), 1, 32'h0,        32'h0,        4'h0, 0, 4'd0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 3, 4'h1, pk(3,0,0,0), 1, 32'h0,        32'h0,        4'h0, 0, 4'd0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 4'h1, pk(3,0,0,0), 1, 32'h0,        32'h0,        4'h1, 1, 4'd1));
    tbl.push_back(mk(0, 1, 3, 32'hA5,       0, 0, 4'h1, pk(3,0,0,0), 1, 32'hA5,       32'h0,        4'h0, 0, 4'd1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 4'h1, pk(3,0,0,0), 1, 32'hA5,       32'h0,        4'h0, 0, 4'd0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 4, 4'h1, pk(4,0,0,0), 1, 32'h0,        32'h0,        4'h0, 0, 4'd0));
    tbl.push_back(mk(0, 1, 4, 32'h44,       1, 4, 4'h1, pk(4,0,0,0), 1, 32'h44,       32'h0,        4'h0, 0, 4'd1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 4'h1, pk(4,0,0,0), 1, 32'h44,       32'h0,        4'h1, 1, 4'd1));
    tbl.push_back(mk(0, 1, 4, 32'h55,       1, 6, 4'h3, pk(4,6,0,0), 1, 32'h55,       32'h0,        4'h0, 0, 4'd1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 4'h3, pk(4,6,0,0), 1, 32'h55,       32'h0,        4'h2, 1, 4'd1));

    #1;
    for (int k = 0; k < tbl.size(); k++) begin
      rst = tbl[k].rst; we = tbl[k].we; wa = tbl[k].wa; wd = tbl[k].wd;
      issue = tbl[k].issue; issue_addr = tbl[k].ia; ren = tbl[k].ren; ra = tbl[k].ra;
      settle();
      if (tbl[k].chk) begin
        chk($sformatf("row%0d_rd0", k),   rd[31:0],  tbl[k].e_rd0);
        chk($sformatf("row%0d_rd1", k),   rd[63:32], tbl[k].e_rd1);
        chk($sformatf("row%0d_rbusy", k), rbusy,     tbl[k].e_rbusy);
        chk($sformatf("row%0d_stall", k), stall,     tbl[k].e_stall);
        chk($sformatf("row%0d_pend", k),  pend_cnt,  tbl[k].e_pend);
      end
      tick();
    end

    // Saturate the scoreboard: r6 is already busy, so seven issues leave 7 pending
    for (int r = 1; r < DEPTH; r++) begin
      idle(); issue = 1; issue_addr = ADDR_W'(r);
      settle(); tick();
    end
    idle(); ren = 4'hF; ra = pk(1,3,5,7);
    settle();
    chk("sat_pend",  pend_cnt, 4'd7);
    chk("sat_rbusy", rbusy,    4'hF);
    chk("sat_stall", stall,    1'b1);
    tick();
    idle(); ren = 4'h0; ra = pk(2,4,6,7);
    settle();
    chk("sat_noren_stall", stall, 1'b0);
    chk("sat_noren_rbusy", rbusy, 4'hF);
    tick();
    // Re-issue to a busy register must not push the counter past 7
    idle(); issue = 1; issue_addr = 3'd2;
    settle(); tick();
    idle();
    settle();
    chk("sat_reissue_pend", pend_cnt, 4'd7);
    tick();

    // Reset in the middle of activity discards everything, concurrent we/issue included
    idle(); rst = 1; we = 1; wa = 3'd3; wd = 32'hBAD; issue = 1; issue_addr = 3'd5;
    settle(); tick();
    idle(); ren = 4'hF; ra = pk(3,7,4,5);
    settle();
    chk("midrst_rd",    rd,       128'h0);
    chk("midrst_rbusy", rbusy,    4'h0);
    chk("midrst_stall", stall,    1'b0);
    chk("midrst_pend",  pend_cnt, 4'd0);
    tick();

    // Randomised traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(0, 39) == 0);
      we         = $urandom_range(0, 1) == 1;
      wa         = ADDR_W'($urandom_range(0, DEPTH - 1));
      wd         = $urandom;
      issue      = $urandom_range(0, 1) == 1;
      issue_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      ren        = NRD'($urandom_range(0, 15));
      ra         = NRD*ADDR_W'($urandom);
      settle();
      model_check(c);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
